argmax_ctrl: RTL and testbench
==============================

ARGMAX_CTRL -- requirements
Module: argmax_ctrl

Interface
REQ-001 Parameter N, default 8: number of elements per search; legal range 2..16.
REQ-002 Parameter W, default 4: element width in bits; the only supported value is 4.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a search; honoured only in IDLE.
REQ-006 in_valid  input  1  in_data carries an element.
REQ-007 in_data  input  W  element value, unsigned.
REQ-008 in_ready  output  1  block accepts an element this cycle.
REQ-009 busy  output  1  high in COLLECT and DONE.
REQ-010 out_valid  output  1  result is available.
REQ-011 out_max  output  W  maximum value found.
REQ-012 out_idx  output  $clog2(N)  zero-based position of out_max in the input sequence.
REQ-013 out_ready  input  1  consumer takes the result.

Function
REQ-014 FSM states: IDLE, COLLECT, DONE.
- IDLE->COLLECT on start.
- COLLECT->DONE on acceptance of element N-1.
- DONE->IDLE on out_valid && out_ready.
REQ-015 Acceptance of an element means in_valid && in_ready; in_ready = (state==COLLECT), combinational from state only and independent of in_valid.
REQ-016 Element count cnt (width $clog2(N)):
- cleared to 0 on IDLE->COLLECT;
- incremented on each acceptance;
- never wraps within a search; the terminal count is N-1.
REQ-017 First accepted element (cnt==0) loads unconditionally: run_max<=in_data, run_idx<=0.
REQ-018 Later elements: if in_data > run_max (strict unsigned compare), run_max<=in_data and run_idx<=cnt; otherwise both hold.
- Ties keep the earliest index.
REQ-019 run_max next-value selection SHALL be a 2:1 W-bit select between held run_max and in_data, with select = load condition.
REQ-020 Cycles in COLLECT without in_valid SHALL change no state; gaps of any length are allowed.
REQ-021 out_valid = (state==DONE); out_max/out_idx SHALL drive run_max/run_idx and stay stable while out_valid && !out_ready.
REQ-022 Latency: out_valid rises on the cycle after the Nth acceptance; minimum search duration is N+1 cycles from start to out_valid.
REQ-023 start in COLLECT or DONE SHALL be ignored with no effect on count, result or state.
REQ-024 start and out_ready handshake in the same cycle in DONE: return to IDLE only; start is not honoured and a new start is needed.
REQ-025 in_valid while in IDLE or DONE SHALL be ignored (in_ready low).
REQ-026 All-equal input SHALL yield out_idx=0.
REQ-027 out_max/out_idx hold their last values in IDLE until overwritten by the next search's first element.

Reset
REQ-028 rst_n low SHALL asynchronously force:
- state=IDLE, cnt=0, run_max=0, run_idx=0;
- in_ready=0, busy=0, out_valid=0, out_max=0, out_idx=0.
REQ-029 Reset mid-search (COLLECT or DONE) SHALL abort the search with no result produced; the first rising edge after deassertion operates from IDLE.

Structure
REQ-030 Package argmax_pkg SHALL hold:
- the W default;
- the state enum type (IDLE, COLLECT, DONE).
REQ-031 REQ-019 selection SHALL be an instance of the team's existing 4-bit 2:1 mux, mux2, with ports a, b, adr, y; adr=1 selects in_data.
- No other sub-modules.
REQ-032 Comparator, counter and FSM SHALL be written inline in argmax_ctrl.

Verification
REQ-033 N=8, start, then back-to-back 3,7,2,9,9,1,0,5 -> out_valid on the cycle after the 8th acceptance; out_max=9, out_idx=3.
REQ-034 N=8, input 4,4,4,4,4,4,4,4 -> out_max=4, out_idx=0; input 0,0,0,0,0,0,0,15 -> out_max=15, out_idx=7.
REQ-035 N=8, in_valid toggled randomly with gaps up to 5 cycles, input 1..8 -> out_max=8, out_idx=7; count not advanced during gaps.
REQ-036 N=8, out_ready held low 10 cycles in DONE -> out_valid, out_max and out_idx stable throughout; start pulses during COLLECT and DONE ignored.
REQ-037 rst_n pulsed low after the 4th acceptance -> all outputs 0 immediately (asynchronously); new search 2,1,1,1,1,1,1,1 -> out_max=2, out_idx=0.
REQ-038 N=8, out_ready high and start pulsed in the same DONE cycle -> state IDLE next cycle, busy=0; a fresh start then begins a new search.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared types and defaults for the argmax search controller.
package argmax_pkg;
    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/mux2.sv
// 4-bit 2:1 mux; adr=1 selects b.
module mux2 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       adr,
    output logic [3:0] y
);
    assign y = adr ? b : a;
endmodule

// File: rtl/argmax_ctrl.sv
// Streams N unsigned elements and reports the maximum and the index of its
// first occurrence; result is held until the consumer handshakes it.
module argmax_ctrl
    import argmax_pkg::*;
#(
    parameter int N = 8,
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 out_valid,
    output logic [W-1:0]         out_max,
    output logic [$clog2(N)-1:0] out_idx,
    input  logic                 out_ready
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state, state_nxt;
    logic [IW-1:0] cnt;
    logic [W-1:0]  run_max, max_nxt;
    logic [IW-1:0] run_idx;
    logic          acc, load, last;

    assign in_ready  = (state == COLLECT);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_max   = run_max;
    assign out_idx   = run_idx;

    assign acc  = in_valid && in_ready;
    assign last = acc && (cnt == LAST);
    // Strict compare keeps the earliest index on ties.
    assign load = acc && ((cnt == '0) || (in_data > run_max));

    mux2 u_max_sel (
        .a   (run_max),
        .b   (in_data),
        .adr (load),
        .y   (max_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            run_max <= '0;
            run_idx <= '0;
        end else begin
            state   <= state_nxt;
            run_max <= max_nxt;
            if (load) run_idx <= cnt;
            if (state == IDLE && start) cnt <= '0;
            else if (acc && !last)      cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_argmax_ctrl.sv
// Directed bench for argmax_ctrl (N=8, W=4) with hand-computed results.
module tb_argmax_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       out_valid;
    logic [3:0] out_max;
    logic [2:0] out_idx;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    argmax_ctrl #(.N(8), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds 8 elements (v[0] first); gaps of 0..maxgap cycles carry junk data.
    task automatic feed(input logic [0:7][3:0] v, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data  = 4'hF;
                tick();
            end
            in_valid = 1'b1;
            in_data  = v[i];
            if (i == 7) chk("no_result_before_last", {31'd0, out_valid}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic result(input string tag, input logic [3:0] m, input logic [2:0] idx);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_max"},   {28'd0, out_max},   {28'd0, m});
        chk({tag, "_idx"},   {29'd0, out_idx},   {29'd0, idx});
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_max",   {28'd0, out_max},   32'd0);
        chk("rst_out_idx",   {29'd0, out_idx},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // back-to-back search, tie at 9 keeps index 3
        pulse_start();
        chk("collect_in_ready", {31'd0, in_ready}, 32'd1);
        chk("collect_busy",     {31'd0, busy},     32'd1);
        feed({4'd3, 4'd7, 4'd2, 4'd9, 4'd9, 4'd1, 4'd0, 4'd5}, 0);
        result("b2b", 4'd9, 3'd3);
        chk("done_busy", {31'd0, busy}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        drain();
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_busy",      {31'd0, busy},      32'd0);
        // in_valid in IDLE is ignored and the previous result is held
        in_valid = 1'b1; in_data = 4'hF;
        tick();
        in_valid = 1'b0;
        chk("idle_hold_max", {28'd0, out_max}, 32'd9);
        chk("idle_hold_idx", {29'd0, out_idx}, 32'd3);

        pulse_start();
        feed({4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}, 0);
        result("alleq", 4'd4, 3'd0);
        drain();

        pulse_start();
        feed({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15}, 0);
        result("lastmax", 4'd15, 3'd7);
        drain();

        // gapped stream; junk 15 during gaps must not be taken
        pulse_start();
        feed({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}, 5);
        result("gaps", 4'd8, 3'd7);
        drain();

        // start during COLLECT ignored, then stall in DONE with start pulses
        pulse_start();
        in_valid = 1'b1; in_data = 4'd5; tick();
        in_data = 4'd1; tick();
        in_valid = 1'b0;
        pulse_start();
        chk("start_in_collect", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = 4'd6; tick();
        in_data = 4'd2; tick();
        in_data = 4'd7; tick();
        in_data = 4'd3; tick();
        in_data = 4'd0; tick();
        in_data = 4'd4; tick();
        in_valid = 1'b0;
        result("stall0", 4'd7, 3'd4);
        for (int c = 0; c < 10; c++) begin
            start = (c == 3 || c == 7);
            tick();
            result("stall", 4'd7, 3'd4);
        end
        start = 1'b0;
        drain();
        chk("stall_released", {31'd0, out_valid}, 32'd0);

        // async reset after 4th acceptance
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin in_data = 4'd9; tick(); end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("arst_in_ready", {31'd0, in_ready},  32'd0);
        chk("arst_busy",     {31'd0, busy},      32'd0);
        chk("arst_valid",    {31'd0, out_valid}, 32'd0);
        chk("arst_max",      {28'd0, out_max},   32'd0);
        chk("arst_idx",      {29'd0, out_idx},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_idle", {31'd0, busy}, 32'd0);
        pulse_start();
        feed({4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, 0);
        result("post_rst", 4'd2, 3'd0);

        // start together with the DONE handshake only returns to IDLE
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("hs_start_busy",  {31'd0, busy},      32'd0);
        chk("hs_start_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("hs_start_ready", {31'd0, in_ready},  32'd0);
        pulse_start();
        feed({4'd6, 4'd2, 4'd11, 4'd3, 4'd11, 4'd10, 4'd1, 4'd0}, 0);
        result("fresh", 4'd11, 3'd2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
